// File: rtl/floor_sched_pkg.sv
// Shared types and constants for the floor request scheduler.
package floor_sched_pkg;

   localparam int unsigned FLOOR_W = 4;

   typedef enum logic [1:0] {
      Idle,
      ServeUp,
      ServeDown,
      Dwell
   } sched_state_e;

   function automatic int unsigned dwell_cnt_w(input int unsigned cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// One call button: 2-flop synchronizer, optional debounce filter, rising-edge pulse.
// Define DEBOUNCE_EN to insert the DEBOUNCE_CYCLES stable-sample filter.
module btn_sync_edge #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   logic sync1_q, sync2_q;
   logic level, level_prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
      end
   end

`ifdef DEBOUNCE_EN
   localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            filt_q, filt_d;

   // Counts consecutive samples that disagree with the filtered level.
   always_comb begin
      db_cnt_d = '0;
      filt_d   = filt_q;
      if (sync2_q != filt_q) begin
         if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            filt_d = sync2_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt_q <= '0;
         filt_q   <= 1'b0;
      end else begin
         db_cnt_q <= db_cnt_d;
         filt_q   <= filt_d;
      end
   end

   assign level = filt_q;
`else
   assign level = sync2_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_prev_q <= 1'b0;
      end else begin
         level_prev_q <= level;
      end
   end

   assign press = level & ~level_prev_q;

endmodule

// File: rtl/floor_request_scheduler.sv
// Latches call buttons and picks the next target floor with SCAN ordering.
// Define DEBOUNCE_EN to debounce each button for DEBOUNCE_CYCLES clocks.
module floor_request_scheduler #(
   parameter int unsigned NUM_FLOORS      = 10,
   parameter int unsigned DWELL_CYCLES    = 100000,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] call_btn,
   input  logic [3:0]            current_floor,
   input  logic                  car_idle,
   output logic [3:0]            requested_floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  dir_up,
   output logic                  door_open
);

   import floor_sched_pkg::*;

   localparam int unsigned        CNT_W      = dwell_cnt_w(DWELL_CYCLES);
   localparam logic [CNT_W-1:0]   DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);

   logic [NUM_FLOORS-1:0] press, cur_oh, pend_q, pend_d;
   logic [FLOOR_W-1:0]    cur, req_q, req_d, lo_above, hi_below;
   logic                  any_above, any_below, pend_at_cur, arrive, enter_dwell;
   logic                  dir_q, dir_d, door_q, door_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   sched_state_e          state_q, state_d;

   for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_btn
      btn_sync_edge #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn (
         .clk  (clk),
         .rst  (rst),
         .btn  (call_btn[i]),
         .press(press[i])
      );
   end

   assign cur         = (current_floor > TOP_FLOOR) ? TOP_FLOOR : current_floor;
   assign cur_oh      = NUM_FLOORS'(1) << cur;
   assign pend_at_cur = |(pend_q & cur_oh);
   assign arrive      = car_idle && (cur == req_q) && pend_at_cur;

   // Nearest pending floor strictly above and strictly below the car.
   always_comb begin
      any_above = 1'b0;
      any_below = 1'b0;
      lo_above  = '0;
      hi_below  = '0;
      for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
         if (pend_q[i] && (i > int'(cur))) begin
            any_above = 1'b1;
            lo_above  = FLOOR_W'(i);
         end
      end
      for (int i = 0; i < int'(NUM_FLOORS); i++) begin
         if (pend_q[i] && (i < int'(cur))) begin
            any_below = 1'b1;
            hi_below  = FLOOR_W'(i);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      dir_d       = dir_q;
      door_d      = door_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q | press;
      enter_dwell = 1'b0;
      unique case (state_q)
         Idle: begin
            req_d = cur;
            if (pend_at_cur && car_idle) begin
               enter_dwell = 1'b1;
            end else if (any_above) begin
               state_d = ServeUp;
               dir_d   = 1'b1;
               req_d   = lo_above;
            end else if (any_below) begin
               state_d = ServeDown;
               dir_d   = 1'b0;
               req_d   = hi_below;
            end
         end
         ServeUp: begin
            if (arrive) begin
               enter_dwell = 1'b1;
            end else if (pend_at_cur) begin
               req_d = cur; // keep the car's own floor targeted until it settles
            end else if (any_above) begin
               req_d = lo_above;
            end else if (any_below) begin
               state_d = ServeDown;
               dir_d   = 1'b0;
               req_d   = hi_below;
            end else begin
               state_d = Idle;
               req_d   = cur;
            end
         end
         ServeDown: begin
            if (arrive) begin
               enter_dwell = 1'b1;
            end else if (pend_at_cur) begin
               req_d = cur;
            end else if (any_below) begin
               req_d = hi_below;
            end else if (any_above) begin
               state_d = ServeUp;
               dir_d   = 1'b1;
               req_d   = lo_above;
            end else begin
               state_d = Idle;
               req_d   = cur;
            end
         end
         Dwell: begin
            pend_d = (pend_q | press) & ~cur_oh;
            if (|(press & cur_oh)) begin
               cnt_d = DWELL_LOAD;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               door_d = 1'b0;
               if (dir_q && any_above) begin
                  state_d = ServeUp;
                  req_d   = lo_above;
               end else if (!dir_q && any_below) begin
                  state_d = ServeDown;
                  req_d   = hi_below;
               end else if (any_below) begin
                  state_d = ServeDown;
                  dir_d   = 1'b0;
                  req_d   = hi_below;
               end else if (any_above) begin
                  state_d = ServeUp;
                  dir_d   = 1'b1;
                  req_d   = lo_above;
               end else begin
                  state_d = Idle;
                  req_d   = cur;
               end
            end
         end
         default: state_d = Idle;
      endcase

      // Clearing the served floor wins over a same-cycle press of that floor.
      if (enter_dwell) begin
         state_d = Dwell;
         req_d   = cur;
         door_d  = 1'b1;
         cnt_d   = DWELL_LOAD;
         pend_d  = (pend_q | press) & ~cur_oh;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= Idle;
         req_q   <= '0;
         pend_q  <= '0;
         dir_q   <= 1'b1;
         door_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         pend_q  <= pend_d;
         dir_q   <= dir_d;
         door_q  <= door_d;
         cnt_q   <= cnt_d;
      end
   end

   assign requested_floor = req_q;
   assign pending         = pend_q;
   assign dir_up          = dir_q;
   assign door_open       = door_q;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Scoreboard bench for floor_request_scheduler: cycle-tagged expectations checked by a monitor.
module tb_floor_request_scheduler;

   localparam int NF = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NF-1:0] call_btn = '0;
   logic [3:0]    current_floor = '0;
   logic          car_idle = 1'b1;
   logic [3:0]    requested_floor;
   logic [NF-1:0] pending;
   logic          dir_up;
   logic          door_open;

   int cyc   = 0;
   int total = 0;
   int bad   = 0;

   typedef struct {
      int            cyc;
      string         name;
      logic [3:0]    req;
      logic [NF-1:0] pend;
      logic          dir;
      logic          door;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   floor_request_scheduler #(
      .NUM_FLOORS     (NF),
      .DWELL_CYCLES   (8),
      .DEBOUNCE_CYCLES(16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .call_btn       (call_btn),
      .current_floor  (current_floor),
      .car_idle       (car_idle),
      .requested_floor(requested_floor),
      .pending        (pending),
      .dir_up         (dir_up),
      .door_open      (door_open)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: outputs are sampled on the falling edge of the tagged cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_e = sb.pop_front();
         total++;
         if (mon_e.cyc != cyc) begin
            bad++;
            $display("FAIL %s: sample cycle %0d missed (now %0d)", mon_e.name, mon_e.cyc, cyc);
         end else if (requested_floor !== mon_e.req || pending !== mon_e.pend ||
                      dir_up !== mon_e.dir || door_open !== mon_e.door) begin
            bad++;
            $display("FAIL %s: got req=%0d pend=%b dir=%b door=%b, want req=%0d pend=%b dir=%b door=%b",
                     mon_e.name, requested_floor, pending, dir_up, door_open,
                     mon_e.req, mon_e.pend, mon_e.dir, mon_e.door);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [NF-1:0] fb(input int f);
      logic [NF-1:0] one;
      one = NF'(1);
      return one << f;
   endfunction

   task automatic chk(input int dly, input string nm, input int req, input logic [NF-1:0] pend,
                      input logic dir, input logic door);
      exp_t e;
      e.cyc  = cyc + dly;
      e.name = nm;
      e.req  = 4'(req);
      e.pend = pend;
      e.dir  = dir;
      e.door = door;
      sb.push_back(e);
   endtask

   // Raises reset right after an edge so the check before the next edge shows it is asynchronous.
   task automatic do_reset();
      tick(2);
      rst = 1'b1;
      chk(0, "reset", 0, '0, 1'b1, 1'b0);
      tick(1);
      rst = 1'b0;
   endtask

   initial begin
      tick(1);
      do_reset();

`ifdef DEBOUNCE_EN
      current_floor = 4'd0; car_idle = 1'b0;
      do_reset();
      call_btn[2] = 1'b1;
      tick(5);
      call_btn[2] = 1'b0;
      tick(20);
      chk(0, "db_glitch", 0, '0, 1'b1, 1'b0);
      call_btn[2] = 1'b1;
      chk(18, "db_early", 0, '0, 1'b1, 1'b0);
      chk(19, "db_pend", 0, fb(2), 1'b1, 1'b0);
      chk(20, "db_tgt", 2, fb(2), 1'b1, 1'b0);
      tick(40);
      call_btn[2] = 1'b0;
`else
      // Press from idle at floor 0.
      call_btn[3] = 1'b1;
      chk(2, "t1_latency", 0, '0, 1'b1, 1'b0);
      chk(3, "t1_pend", 0, fb(3), 1'b1, 1'b0);
      chk(4, "t1_target", 3, fb(3), 1'b1, 1'b0);
      tick(4);
      call_btn[3] = 1'b0;

      // Moving up from 2 toward 7, then a nearer press at 5.
      current_floor = 4'd2; car_idle = 1'b0;
      do_reset();
      call_btn[7] = 1'b1;
      chk(1, "t2_idle", 2, '0, 1'b1, 1'b0);
      chk(3, "t2_pend7", 2, fb(7), 1'b1, 1'b0);
      chk(4, "t2_tgt7", 7, fb(7), 1'b1, 1'b0);
      tick(4);
      call_btn[7] = 1'b0;
      call_btn[5] = 1'b1;
      chk(3, "t2_pend5", 7, fb(5) | fb(7), 1'b1, 1'b0);
      chk(4, "t2_tgt5", 5, fb(5) | fb(7), 1'b1, 1'b0);
      tick(4);
      call_btn[5] = 1'b0;
      current_floor = 4'd5; car_idle = 1'b1;
      chk(1, "t2_arrive", 5, fb(7), 1'b1, 1'b1);
      chk(8, "t2_dwell_end", 5, fb(7), 1'b1, 1'b1);
      chk(9, "t2_next7", 7, fb(7), 1'b1, 1'b0);
      tick(9);

      // At 6 with {2,8}: serve 8, then reverse to 2.
      current_floor = 4'd6; car_idle = 1'b0;
      do_reset();
      call_btn[2] = 1'b1; call_btn[8] = 1'b1;
      chk(3, "t3_pend", 6, fb(2) | fb(8), 1'b1, 1'b0);
      chk(4, "t3_tgt8", 8, fb(2) | fb(8), 1'b1, 1'b0);
      tick(4);
      call_btn = '0;
      current_floor = 4'd8; car_idle = 1'b1;
      chk(1, "t3_arrive8", 8, fb(2), 1'b1, 1'b1);
      chk(9, "t3_reverse", 2, fb(2), 1'b0, 1'b0);
      tick(9);

      // Re-press of the served floor during dwell restarts the dwell.
      current_floor = 4'd4; car_idle = 1'b1;
      do_reset();
      call_btn[4] = 1'b1;
      chk(3, "t4_pend", 4, fb(4), 1'b1, 1'b0);
      chk(4, "t4_dwell", 4, '0, 1'b1, 1'b1);
      tick(4);
      call_btn[4] = 1'b0;
      tick(2);
      call_btn[4] = 1'b1;
      chk(3, "t4_masked", 4, '0, 1'b1, 1'b1);
      chk(6, "t4_restarted", 4, '0, 1'b1, 1'b1);
      chk(10, "t4_last_open", 4, '0, 1'b1, 1'b1);
      chk(11, "t4_close", 4, '0, 1'b1, 1'b0);
      tick(11);
      call_btn[4] = 1'b0;

      // Out-of-range floor report clamps to the top floor.
      current_floor = 4'd12; car_idle = 1'b1;
      do_reset();
      call_btn[9] = 1'b1;
      chk(1, "t5_clamp", 9, '0, 1'b1, 1'b0);
      chk(3, "t5_pend", 9, fb(9), 1'b1, 1'b0);
      chk(4, "t5_dwell", 9, '0, 1'b1, 1'b1);
      tick(4);
      call_btn[9] = 1'b0;
      chk(8, "t5_idle", 9, '0, 1'b1, 1'b0);
      tick(8);

      // Reset in the middle of a downward sweep.
      current_floor = 4'd5; car_idle = 1'b0;
      do_reset();
      call_btn[1] = 1'b1;
      chk(3, "t6_pend1", 5, fb(1), 1'b1, 1'b0);
      chk(4, "t6_down", 1, fb(1), 1'b0, 1'b0);
      tick(2);
      call_btn[1] = 1'b0;
      call_btn[9] = 1'b1;
      chk(3, "t6_both", 1, fb(1) | fb(9), 1'b0, 1'b0);
      tick(3);
      call_btn[9] = 1'b0;
      do_reset();
      chk(2, "t6_quiet", 5, '0, 1'b1, 1'b0);
`endif

      for (int i = 0; i < 40 && sb.size() > 0; i++) tick(1);
      if (sb.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
